// File: rtl/fetch_ctrl_if.sv
// Bundle of every signal exchanged between the fetch sequencing controller and
// its environment (redirect resolvers, backend, debug/halt logic and the fetch
// wrapper). The controller connects through the slave modport; whoever drives
// the requests and consumes the fetch-wrapper controls uses the master modport.
// Optional performance counter outputs exist only when FETCH_CTRL_PERF_EN is
// defined.
interface fetch_ctrl_if #(
   parameter int INST_ADDR_WIDTH = 32,
   parameter int CNT_WIDTH       = 32
);

   // Requests into the controller
   logic                       backend_stall;
   logic                       sb_redirect;
   logic [INST_ADDR_WIDTH-1:0] sb_target;
   logic                       uj_redirect;
   logic [INST_ADDR_WIDTH-1:0] uj_target;
   logic                       jalr_redirect;
   logic [INST_ADDR_WIDTH-1:0] jalr_target;
   logic                       halt_req;
   logic                       resume;

   // Controls towards the fetch wrapper and debug visibility
   logic [1:0]                 next_pc_sel;
   logic [INST_ADDR_WIDTH-1:0] SB_Type_addr;
   logic [INST_ADDR_WIDTH-1:0] UJ_Type_addr;
   logic [INST_ADDR_WIDTH-1:0] JALR_Type_addr;
   logic                       ifu_stall;
   logic                       fetch_valid;
   logic [2:0]                 ctrl_state;

`ifdef FETCH_CTRL_PERF_EN
   logic [CNT_WIDTH-1:0]       perf_stall_cycles;
   logic [CNT_WIDTH-1:0]       perf_redirects;
   logic [CNT_WIDTH-1:0]       perf_flush_cycles;
`endif

   modport master (
      output backend_stall,
      output sb_redirect,
      output sb_target,
      output uj_redirect,
      output uj_target,
      output jalr_redirect,
      output jalr_target,
      output halt_req,
      output resume,
      input  next_pc_sel,
      input  SB_Type_addr,
      input  UJ_Type_addr,
      input  JALR_Type_addr,
      input  ifu_stall,
      input  fetch_valid,
      input  ctrl_state
`ifdef FETCH_CTRL_PERF_EN
      ,
      input  perf_stall_cycles,
      input  perf_redirects,
      input  perf_flush_cycles
`endif
   );

   modport slave (
      input  backend_stall,
      input  sb_redirect,
      input  sb_target,
      input  uj_redirect,
      input  uj_target,
      input  jalr_redirect,
      input  jalr_target,
      input  halt_req,
      input  resume,
      output next_pc_sel,
      output SB_Type_addr,
      output UJ_Type_addr,
      output JALR_Type_addr,
      output ifu_stall,
      output fetch_valid,
      output ctrl_state
`ifdef FETCH_CTRL_PERF_EN
      ,
      output perf_stall_cycles,
      output perf_redirects,
      output perf_flush_cycles
`endif
   );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller.
// Merges branch/JAL/JALR redirects, backend back-pressure and halt/resume into
// a single PC-update decision per cycle, and inserts flush bubbles after every
// accepted redirect so wrong-path instructions never show up as valid.
// States: RST_WAIT holds fetch after reset, RUN fetches sequentially, FLUSH
// drains wrong-path bubbles, HALT parks fetch until resume.
// Optional feature: define FETCH_CTRL_PERF_EN to add three performance
// counters (stall cycles, accepted redirects, flush cycles).
module fetch_ctrl #(
   parameter int INST_ADDR_WIDTH = 32,
   parameter int FLUSH_CYCLES    = 1,
   parameter int RESET_HOLD      = 2,
   parameter int CNT_WIDTH       = 32
) (
   input logic         clk,
   input logic         reset,
   fetch_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      RST_WAIT = 3'd0,
      RUN      = 3'd1,
      FLUSH    = 3'd2,
      HALT     = 3'd3
   } state_t;

   localparam logic [1:0] SEL_PC4  = 2'd0;
   localparam logic [1:0] SEL_SB   = 2'd1;
   localparam logic [1:0] SEL_UJ   = 2'd2;
   localparam logic [1:0] SEL_JALR = 2'd3;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [3:0] HOLD_LOAD  = 4'(RESET_HOLD - 1);

   // Parameter sanity: the counters are sized for these ranges only.
   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
      $error("fetch_ctrl: FLUSH_CYCLES must be within 1..7");
   end
   if (RESET_HOLD < 1 || RESET_HOLD > 15) begin : g_bad_reset_hold
      $error("fetch_ctrl: RESET_HOLD must be within 1..15");
   end
   if (INST_ADDR_WIDTH < 2) begin : g_bad_addr_width
      $error("fetch_ctrl: INST_ADDR_WIDTH must be at least 2");
   end
   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("fetch_ctrl: CNT_WIDTH must be at least 1");
   end

   state_t     state;
   state_t     state_nxt;
   logic [3:0] hold_cnt;
   logic [3:0] hold_nxt;
   logic [2:0] flush_cnt;
   logic [2:0] flush_nxt;
   logic       valid_q;
   logic       valid_nxt;

   logic       redirect_req;
   logic [1:0] redirect_sel;
   logic       live_state;
   logic       halt_take;
   logic       accept;
   logic [1:0] pc_sel;
   logic       stall;

   logic [INST_ADDR_WIDTH-1:0] sb_addr;
   logic [INST_ADDR_WIDTH-1:0] uj_addr;
   logic [INST_ADDR_WIDTH-1:0] jalr_addr;

   // Fixed-priority redirect arbitration: JALR wins over SB, SB over UJ.
   // Losers are simply dropped; ordering between older and younger
   // instructions is the resolver's job, not ours.
   always_comb begin
      redirect_req = 1'b0;
      redirect_sel = SEL_PC4;
      if (bus.jalr_redirect) begin
         redirect_req = 1'b1;
         redirect_sel = SEL_JALR;
      end else if (bus.sb_redirect) begin
         redirect_req = 1'b1;
         redirect_sel = SEL_SB;
      end else if (bus.uj_redirect) begin
         redirect_req = 1'b1;
         redirect_sel = SEL_UJ;
      end
   end

   // Redirects and halts are only honoured while fetch is live; a halt
   // request in the same cycle suppresses the redirect entirely.
   always_comb begin
      live_state = (state == RUN) || (state == FLUSH);
      halt_take  = live_state && bus.halt_req;
      accept     = live_state && !bus.halt_req && redirect_req;
   end

   // Fetch-wrapper controls: an accepted redirect forces the PC update
   // through even under back-pressure, otherwise live states follow the
   // backend and all other states keep fetch frozen.
   always_comb begin
      pc_sel = SEL_PC4;
      stall  = 1'b1;
      case (state)
         RUN, FLUSH: begin
            if (accept) begin
               pc_sel = redirect_sel;
               stall  = 1'b0;
            end else begin
               stall  = bus.backend_stall;
            end
         end
         default: begin
            pc_sel = SEL_PC4;
            stall  = 1'b1;
         end
      endcase
   end

   // Next-state, counter and valid-bit decisions for the coming edge.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      flush_nxt = flush_cnt;
      valid_nxt = valid_q;
      case (state)
         RST_WAIT: begin
            valid_nxt = 1'b0;
            if (hold_cnt == 4'd0) begin
               state_nxt = RUN;
            end else begin
               hold_nxt = hold_cnt - 4'd1;
            end
         end
         RUN: begin
            if (halt_take) begin
               state_nxt = HALT;
               valid_nxt = 1'b0;
            end else if (accept) begin
               state_nxt = FLUSH;
               flush_nxt = FLUSH_LOAD;
               valid_nxt = 1'b0;
            end else if (!stall) begin
               valid_nxt = 1'b1;
            end
         end
         FLUSH: begin
            valid_nxt = 1'b0;
            if (halt_take) begin
               state_nxt = HALT;
            end else if (accept) begin
               flush_nxt = FLUSH_LOAD;
            end else if (!stall) begin
               if (flush_cnt == 3'd0) begin
                  state_nxt = RUN;
                  valid_nxt = 1'b1;
               end else begin
                  flush_nxt = flush_cnt - 3'd1;
               end
            end
         end
         HALT: begin
            valid_nxt = 1'b0;
            if (bus.resume && !bus.halt_req) begin
               state_nxt = FLUSH;
               flush_nxt = FLUSH_LOAD;
            end
         end
         default: begin
            state_nxt = RST_WAIT;
            hold_nxt  = HOLD_LOAD;
            flush_nxt = 3'd0;
            valid_nxt = 1'b0;
         end
      endcase
   end

   // State register; reset discards any pending redirect and both counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RST_WAIT;
         hold_cnt  <= HOLD_LOAD;
         flush_cnt <= 3'd0;
         valid_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         flush_cnt <= flush_nxt;
         valid_q   <= valid_nxt;
      end
   end

   assign sb_addr   = bus.sb_target;
   assign uj_addr   = bus.uj_target;
   assign jalr_addr = bus.jalr_target;

   assign bus.SB_Type_addr   = sb_addr;
   assign bus.UJ_Type_addr   = uj_addr;
   assign bus.JALR_Type_addr = jalr_addr;
   assign bus.next_pc_sel    = pc_sel;
   assign bus.ifu_stall      = stall;
   assign bus.fetch_valid    = valid_q;
   assign bus.ctrl_state     = state;

`ifdef FETCH_CTRL_PERF_EN
   logic [CNT_WIDTH-1:0] stall_cycles_q;
   logic [CNT_WIDTH-1:0] redirects_q;
   logic [CNT_WIDTH-1:0] flush_cycles_q;

   // Free-running event counters, wrapping naturally at 2^CNT_WIDTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         redirects_q    <= '0;
         flush_cycles_q <= '0;
      end else begin
         if (live_state && stall) begin
            stall_cycles_q <= stall_cycles_q + 1'b1;
         end
         if (accept) begin
            redirects_q <= redirects_q + 1'b1;
         end
         if (state == FLUSH) begin
            flush_cycles_q <= flush_cycles_q + 1'b1;
         end
      end
   end

   assign bus.perf_stall_cycles = stall_cycles_q;
   assign bus.perf_redirects    = redirects_q;
   assign bus.perf_flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. The main instance uses FLUSH_CYCLES=1;
// a second instance with FLUSH_CYCLES=4 shares the same stimulus so a reset
// can land while it still has flush bubbles outstanding.
module tb_fetch_ctrl;

   logic clk = 1'b0;
   logic reset;

   // 10-unit clock period
   always #5 clk = ~clk;

   fetch_ctrl_if #(.INST_ADDR_WIDTH(32), .CNT_WIDTH(32)) bus ();
   fetch_ctrl_if #(.INST_ADDR_WIDTH(32), .CNT_WIDTH(32)) bus4 ();

   fetch_ctrl #(
      .INST_ADDR_WIDTH(32),
      .FLUSH_CYCLES   (1),
      .RESET_HOLD     (2),
      .CNT_WIDTH      (32)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   fetch_ctrl #(
      .INST_ADDR_WIDTH(32),
      .FLUSH_CYCLES   (4),
      .RESET_HOLD     (2),
      .CNT_WIDTH      (32)
   ) dut4 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus4.slave)
   );

   assign bus4.backend_stall = bus.backend_stall;
   assign bus4.sb_redirect   = bus.sb_redirect;
   assign bus4.sb_target     = bus.sb_target;
   assign bus4.uj_redirect   = bus.uj_redirect;
   assign bus4.uj_target     = bus.uj_target;
   assign bus4.jalr_redirect = bus.jalr_redirect;
   assign bus4.jalr_target   = bus.jalr_target;
   assign bus4.halt_req      = bus.halt_req;
   assign bus4.resume        = bus.resume;

   typedef struct {
      string      tag;
      logic [2:0] state;
      logic       valid;
      logic       stall;
      logic [1:0] sel;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      e = expQ.pop_front();
      cmp({e.tag, ".state"}, 32'(bus.ctrl_state),  32'(e.state));
      cmp({e.tag, ".valid"}, 32'(bus.fetch_valid), 32'(e.valid));
      cmp({e.tag, ".stall"}, 32'(bus.ifu_stall),   32'(e.stall));
      cmp({e.tag, ".sel"},   32'(bus.next_pc_sel), 32'(e.sel));
   endtask

   task automatic applyStimulus(input string tag, input logic rst, input logic bs,
                                input logic sb, input logic uj, input logic jalr,
                                input logic halt, input logic res,
                                input logic [2:0] eState, input logic eValid,
                                input logic eStall, input logic [1:0] eSel);
      exp_t e;
      reset             = rst;
      bus.backend_stall = bs;
      bus.sb_redirect   = sb;
      bus.uj_redirect   = uj;
      bus.jalr_redirect = jalr;
      bus.halt_req      = halt;
      bus.resume        = res;
      e.tag   = tag;
      e.state = eState;
      e.valid = eValid;
      e.stall = eStall;
      e.sel   = eSel;
      expQ.push_back(e);
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence; expected values are written per cycle by hand.
   initial begin
      reset             = 1'b1;
      bus.backend_stall = 1'b0;
      bus.sb_redirect   = 1'b0;
      bus.uj_redirect   = 1'b0;
      bus.jalr_redirect = 1'b0;
      bus.halt_req      = 1'b0;
      bus.resume        = 1'b0;
      bus.sb_target     = 32'h0000_0100;
      bus.uj_target     = 32'h0000_0200;
      bus.jalr_target   = 32'h0000_0300;
      @(posedge clk);
      #1;

      //            tag              rst bs sb uj jr ht rs  state valid stall sel
      applyStimulus("rst_hold",       1, 0, 0, 0, 0, 0, 0,  3'd0, 0, 1, 2'd0);
      applyStimulus("hold1",          0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 1, 2'd0);
      applyStimulus("hold2_ignore",   0, 0, 1, 0, 0, 0, 0,  3'd0, 0, 1, 2'd0);
      applyStimulus("run_first",      0, 0, 0, 0, 0, 0, 0,  3'd1, 0, 0, 2'd0);
      applyStimulus("run_valid",      0, 0, 0, 0, 0, 0, 0,  3'd1, 1, 0, 2'd0);
      applyStimulus("sb_redirect",    0, 0, 1, 0, 0, 0, 0,  3'd1, 1, 0, 2'd1);
      cmp("sb_addr",   bus.SB_Type_addr,   32'h0000_0100);
      cmp("uj_addr",   bus.UJ_Type_addr,   32'h0000_0200);
      cmp("jalr_addr", bus.JALR_Type_addr, 32'h0000_0300);
      applyStimulus("sb_flush",       0, 0, 0, 0, 0, 0, 0,  3'd2, 0, 0, 2'd0);
      applyStimulus("sb_back_run",    0, 0, 0, 0, 0, 0, 0,  3'd1, 1, 0, 2'd0);
      applyStimulus("all_three",      0, 0, 1, 1, 1, 0, 0,  3'd1, 1, 0, 2'd3);
`ifdef FETCH_CTRL_PERF_EN
      cmp("perf_redirects", bus.perf_redirects, 32'd2);
`endif
      applyStimulus("all_flush",      0, 0, 0, 0, 0, 0, 0,  3'd2, 0, 0, 2'd0);
      applyStimulus("uj_stalled",     0, 1, 0, 1, 0, 0, 0,  3'd1, 1, 0, 2'd2);
      applyStimulus("flush_stall_a",  0, 1, 0, 0, 0, 0, 0,  3'd2, 0, 1, 2'd0);
      applyStimulus("flush_stall_b",  0, 1, 0, 0, 0, 0, 0,  3'd2, 0, 1, 2'd0);
      applyStimulus("flush_release",  0, 0, 0, 0, 0, 0, 0,  3'd2, 0, 0, 2'd0);
      applyStimulus("run_bs_a",       0, 1, 0, 0, 0, 0, 0,  3'd1, 1, 1, 2'd0);
      applyStimulus("run_bs_b",       0, 1, 0, 0, 0, 0, 0,  3'd1, 1, 1, 2'd0);
`ifdef FETCH_CTRL_PERF_EN
      cmp("perf_stall_cycles", bus.perf_stall_cycles, 32'd4);
      cmp("perf_flush_cycles", bus.perf_flush_cycles, 32'd5);
`endif
      applyStimulus("halt_uj",        0, 0, 0, 1, 0, 1, 0,  3'd1, 1, 0, 2'd0);
      applyStimulus("halt_ign_sb",    0, 0, 1, 0, 0, 0, 0,  3'd3, 0, 1, 2'd0);
      applyStimulus("halt_both",      0, 0, 0, 0, 0, 1, 1,  3'd3, 0, 1, 2'd0);
      applyStimulus("resume",         0, 0, 0, 0, 0, 0, 1,  3'd3, 0, 1, 2'd0);
      applyStimulus("resume_flush",   0, 0, 0, 0, 0, 0, 0,  3'd2, 0, 0, 2'd0);
      applyStimulus("resume_run",     0, 0, 0, 0, 0, 0, 0,  3'd1, 1, 0, 2'd0);
      applyStimulus("jalr",           0, 0, 0, 0, 1, 0, 0,  3'd1, 1, 0, 2'd3);

      // The FLUSH_CYCLES=4 instance now sits in FLUSH with three bubbles left.
      cmp("dut4_flush.state", 32'(bus4.ctrl_state),  32'd2);
      cmp("dut4_flush.valid", 32'(bus4.fetch_valid), 32'd0);
      applyStimulus("flush_reset",    1, 0, 0, 0, 0, 0, 0,  3'd2, 0, 0, 2'd0);
      cmp("dut4_rst.state", 32'(bus4.ctrl_state),  32'd0);
      cmp("dut4_rst.valid", 32'(bus4.fetch_valid), 32'd0);
      cmp("dut4_rst.stall", 32'(bus4.ifu_stall),   32'd1);
      applyStimulus("post_rst1",      0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 1, 2'd0);
      applyStimulus("post_rst2",      0, 0, 0, 0, 0, 0, 0,  3'd0, 0, 1, 2'd0);
      applyStimulus("post_run",       0, 0, 0, 0, 0, 0, 0,  3'd1, 0, 0, 2'd0);
      applyStimulus("post_valid",     0, 0, 0, 0, 0, 0, 0,  3'd1, 1, 0, 2'd0);

      cmp("queue_drained", 32'(expQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch wrapper. Drives its PC-select, redirect-target and stall inputs, and qualifies its registered outputs with a valid bit.
- Arbitrates redirect requests from branch/jump resolution, backend back-pressure and halt/resume into one PC-update decision per cycle.
- Inserts flush bubbles so wrong-path instructions are never marked valid.

Parameters:
- INST_ADDR_WIDTH, 32, instruction address width; matches the fetch wrapper.
- FLUSH_CYCLES, 1, bubble cycles after an accepted redirect; legal range 1..7.
- RESET_HOLD, 2, cycles fetch is held stalled after reset deasserts; legal range 1..15.
- CNT_WIDTH, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- backend_stall  in  1  decode/rename cannot accept an instruction this cycle
- sb_redirect  in  1  taken conditional branch resolved
- sb_target  in  INST_ADDR_WIDTH  branch target
- uj_redirect  in  1  JAL resolved
- uj_target  in  INST_ADDR_WIDTH  JAL target
- jalr_redirect  in  1  JALR resolved
- jalr_target  in  INST_ADDR_WIDTH  JALR target
- halt_req  in  1  stop fetching (ecall/ebreak/debug)
- resume  in  1  leave HALT
- next_pc_sel  out  2  to fetch wrapper: 0=PC+4, 1=SB, 2=UJ, 3=JALR
- SB_Type_addr / UJ_Type_addr / JALR_Type_addr  out  INST_ADDR_WIDTH each  targets forwarded to the fetch wrapper
- ifu_stall  out  1  fetch wrapper stall/enable
- fetch_valid  out  1  wrapper output registers hold a correct-path instruction
- ctrl_state  out  3  current state, for debug

Behaviour:
- States and encoding:
  - RST_WAIT=0
  - RUN=1
  - FLUSH=2
  - HALT=3
- Reset (synchronous) values:
  - state=RST_WAIT, hold counter=RESET_HOLD-1, flush counter=0.
  - fetch_valid=0, ifu_stall=1, next_pc_sel=0.
- RST_WAIT:
  - ifu_stall=1; counter decrements each cycle.
  - At 0, go to RUN. fetch_valid stays 0.
  - Redirects are ignored.
- Redirect priority: jalr_redirect > sb_redirect > uj_redirect. Only the winner is accepted; losers are dropped, since the older-instruction ordering is the resolver's responsibility.
- Redirect acceptance (in RUN or FLUSH, while halt_req is not asserted):
  - next_pc_sel = winner encoding; ifu_stall=0 that cycle, even if backend_stall=1.
  - At the clock edge: state goes to FLUSH, flush counter loads FLUSH_CYCLES-1, fetch_valid goes to 0.
- next_pc_sel timing:
  - next_pc_sel is combinational and is 0 in every cycle without an accepted redirect.
  - The target outputs are combinational pass-through of the target inputs.
- RUN without redirect:
  - ifu_stall = backend_stall.
  - fetch_valid is set to 1 at the edge when ifu_stall=0; it holds its value when ifu_stall=1.
- FLUSH:
  - ifu_stall = backend_stall; fetch_valid stays 0.
  - The counter decrements only on non-stalled cycles.
  - Leaving FLUSH: on a non-stalled cycle with counter 0, go to RUN and set fetch_valid to 1 at that edge.
  - A new redirect in FLUSH restarts the flush; a stalled FLUSH does not.
- HALT:
  - Entered from RUN or FLUSH on halt_req; halt_req has priority over a same-cycle redirect, and the redirect is dropped.
  - In HALT: ifu_stall=1, fetch_valid=0, redirects ignored.
  - resume (with halt_req low) goes to FLUSH with counter FLUSH_CYCLES-1, then RUN. If halt_req and resume are both high, stay in HALT.
- Reset mid-operation (any state): return to reset values on the next edge. Pending redirect and counters are discarded.
- Counters saturate/underflow: none. The FLUSH and RST_WAIT counters never go below 0.

Optional Feature:
- Macro FETCH_CTRL_PERF_EN.
- When defined, adds three CNT_WIDTH outputs:
  - perf_stall_cycles: cycles with ifu_stall=1 in RUN or FLUSH.
  - perf_redirects: accepted redirects.
  - perf_flush_cycles: cycles spent in FLUSH.
- The counters clear on reset and wrap modulo 2^CNT_WIDTH.
- When undefined, these ports and all counter logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset release, RESET_HOLD=2 -> ifu_stall=1 for exactly 2 cycles after reset drops, then 0; fetch_valid=1 on the edge after the first non-stalled cycle.
- RUN, single cycle of sb_redirect=1 with sb_target=0x100 -> next_pc_sel=1 that cycle; fetch_valid=0 for 1 cycle (FLUSH_CYCLES=1), then 1; SB_Type_addr=0x100.
- jalr_redirect, sb_redirect and uj_redirect all asserted in the same cycle -> next_pc_sel=3, perf_redirects increments by 1.
- Redirect with backend_stall=1 -> ifu_stall=0 in the accept cycle. If backend_stall stays 1 afterwards, the state stays FLUSH and fetch_valid=0 until the first non-stalled cycle.
- halt_req together with uj_redirect -> state HALT, next_pc_sel=0, ifu_stall=1. Then resume -> one FLUSH cycle, then RUN with fetch_valid=1.
- Reset asserted in FLUSH with counter=3 (FLUSH_CYCLES=4) -> next cycle state=RST_WAIT, fetch_valid=0, ifu_stall=1.
